servo_pwm_controller: RTL
=========================

// Module: servo_pwm_controller
// PURPOSE
//  Memory-mapped scheduler for the six servo PWM outputs. Decodes processor dmem writes (wren/address_dmem/data)
//  in a fixed window, holds per-channel target pulse widths, and produces glitch-free frame-aligned PWM.
//  Sits beside RAM in Wrapper; Wrapper muxes rdata over RAM dataOut when hit=1.
// PARAMETERS
//  CLK_HZ        50_000_000  clock frequency; US_DIV = CLK_HZ/1_000_000 (must be >=2, integer)
//  NUM_SERVOS    6           channel count (1..6)
//  BASE_ADDR     12'hF00     window base; 8 word offsets BASE_ADDR+0..+7
//  PERIOD_US     20000       frame length in microseconds
//  MIN_US        500         clamp floor for pulse width
//  MAX_US        2500        clamp ceiling for pulse width (< PERIOD_US)
//  DEFAULT_US    1500        reset pulse width
//  SLEW_STEP_US  10          max width change per frame (SERVO_SLEW_EN only)
// PORTS
//  clock        in   1           system clock, all logic rising-edge
//  reset        in   1           asynchronous, active-high
//  wren         in   1           processor store strobe
//  addr         in   12          dmem word address
//  wdata        in   32          store data
//  hit          out  1           combinational: addr in [BASE_ADDR, BASE_ADDR+7]
//  rdata        out  32          registered readback, 1-cycle latency
//  servo        out  NUM_SERVOS  PWM outputs, registered
//  frame_start  out  1           one-cycle pulse at each frame wrap
// BEHAVIOUR
//  Reset: target[i]=active[i]=DEFAULT_US, en_mask=en_active=0, servo=0, rdata=0, frame_start=0, counters=0, frame_cnt=0.
//  Registers (offset): 0..NUM_SERVOS-1 target width (RW); 6 en_mask[NUM_SERVOS-1:0] (RW); 7 {16'b0,frame_cnt} (RO).
//  Offsets in [NUM_SERVOS,5] read 0, writes ignored. Write to 7 ignored.
//  Write: on clock edge with wren&hit. Width: wdata unsigned; <MIN_US -> MIN_US; >MAX_US (incl. wdata[31:16]!=0) -> MAX_US.
//  Read: rdata <= register at addr every cycle hit=1; rdata <= 0 when hit=0. Readback shows clamped target.
//  Timebase: prescaler 0..US_DIV-1; tick when prescaler==US_DIV-1. us_cnt 0..PERIOD_US-1 advances on tick.
//  Frame wrap: tick with us_cnt==PERIOD_US-1 -> us_cnt=0, frame_start=1 next cycle, frame_cnt+1 (wraps 16 bits),
//   active[i] <= target[i], en_active <= en_mask. Only point where active/en_active change (no mid-pulse glitch).
//  Simultaneous write and wrap on same edge: wrap samples pre-write target; new value applies at following wrap.
//  Output: servo[i] <= en_active[i] & (us_cnt < active[i]); one-cycle lag from us_cnt, high for exactly
//   active[i]*US_DIV clocks per frame. Disabled channel holds 0 for whole frame.
//  First frame after reset: us_cnt starts 0, all channels disabled; first enable takes effect at first wrap.
//  Reset mid-frame: all outputs drop to 0 immediately (async); restart at us_cnt=0.
// CONFIGURATION
//  SERVO_SLEW_EN defined: at wrap, active[i] moves toward target[i] by min(|diff|, SLEW_STEP_US); en_active rising
//   for channel i also loads active[i]=target[i] directly (no ramp from stale value).
//  SERVO_SLEW_EN undefined: active[i] <= target[i] at wrap; SLEW_STEP_US unused.
// STRUCTURE
//  Package servo_pkg: register offset constants (OFF_EN=6, OFF_STAT=7), US_DIV function, width typedef us_t (16 bits).
//  Sub-module servo_pwm_channel: holds active width, slew step (under macro), comparator and output flop;
//   inputs us_cnt, frame wrap strobe, target, enable. Top owns decode, target/en regs, prescaler, us_cnt, readback.
// TESTING  (bench params: CLK_HZ=4_000_000 -> US_DIV=4, PERIOD_US=100, MIN_US=10, MAX_US=90, DEFAULT_US=50, SLEW_STEP_US=5)
//  Reset: assert mid-run -> servo=0, rdata=0, frame_start=0 same cycle; read offset 0 -> 50 one cycle later.
//  Write 30 to off 0, 0x1 to off 6 before wrap -> from next frame servo[0] high 120 clocks of every 400.
//  Clamp: write 3 -> reads 10; write 0x0001_0000 -> reads 90; servo high 40 / 360 clocks.
//  Write 70 to off 1 on same edge as wrap -> that frame uses old width, following frame high 280 clocks.
//  Decode: write to BASE_ADDR+8 and BASE_ADDR-1 -> hit=0, no reg change; write to off 7 -> frame_cnt unchanged.
//  SERVO_SLEW_EN, ch0 enabled at 50, write 70 -> widths 55,60,65,70,70 over successive frames; undefined -> 70 at once.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM controller: register offsets,
// the pulse-width type and the clock-to-microsecond divider helper.
package servo_pkg;

  // Pulse widths and the microsecond counter are 16-bit quantities.
  typedef logic [15:0] us_t;

  // Word offsets inside the 8-word register window.
  localparam logic [2:0] OFF_EN   = 3'd6;
  localparam logic [2:0] OFF_STAT = 3'd7;

  // Clocks per microsecond; the clock must be an integer multiple of 1 MHz.
  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo PWM channel: holds the width and enable used for the current
// frame, and compares them against the shared microsecond counter.
// Optional feature macro: SERVO_SLEW_EN (bounded width change per frame).
module servo_pwm_channel
  import servo_pkg::*;
#(
  parameter int DEFAULT_US = 1500
`ifdef SERVO_SLEW_EN
  , parameter int SLEW_STEP_US = 10
`endif
) (
  input  logic clock,
  input  logic reset,
  input  us_t  us_cnt,
  input  logic wrap,
  input  us_t  target,
  input  logic enable,
  output logic servo
);

  localparam us_t DEFAULT_W = us_t'(DEFAULT_US);

  us_t  active;
  logic en_active;
  us_t  next_active;

`ifdef SERVO_SLEW_EN
  localparam us_t STEP = us_t'(SLEW_STEP_US);

  // Next frame's width: snap to target on a fresh enable, otherwise step toward it.
  always_comb begin
    next_active = active;
    if (enable && !en_active) begin
      next_active = target;
    end else if (target > active) begin
      next_active = ((target - active) > STEP) ? active + STEP : target;
    end else if (target < active) begin
      next_active = ((active - target) > STEP) ? active - STEP : target;
    end
  end
`else
  assign next_active = target;
`endif

  // Width and enable only change at the frame boundary, so a pulse is never cut short.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      active    <= DEFAULT_W;
      en_active <= 1'b0;
    end else if (wrap) begin
      active    <= next_active;
      en_active <= enable;
    end
  end

  // Registered output: high while the frame position is below the active width.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      servo <= 1'b0;
    end else begin
      servo <= en_active & (us_cnt < active);
    end
  end

endmodule

// File: rtl/servo_pwm_controller.sv
// Memory-mapped servo PWM scheduler. Decodes processor stores into an
// 8-word window, keeps per-channel target widths and an enable mask,
// runs the microsecond/frame timebase and provides registered readback.
// Optional feature macro: SERVO_SLEW_EN (forwarded to every channel).
module servo_pwm_controller
  import servo_pkg::*;
#(
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          NUM_SERVOS   = 6,
  parameter logic [11:0] BASE_ADDR    = 12'hF00,
  parameter int          PERIOD_US    = 20000,
  parameter int          MIN_US       = 500,
  parameter int          MAX_US       = 2500,
  parameter int          DEFAULT_US   = 1500,
  parameter int          SLEW_STEP_US = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wren,
  input  logic [11:0]           addr,
  input  logic [31:0]           wdata,
  output logic                  hit,
  output logic [31:0]           rdata,
  output logic [NUM_SERVOS-1:0] servo,
  output logic                  frame_start
);

  localparam int              US_DIV    = us_div(CLK_HZ);
  localparam int              PS_W      = $clog2(US_DIV);
  localparam logic [PS_W-1:0] PS_LAST   = PS_W'(US_DIV - 1);
  localparam us_t             US_LAST   = us_t'(PERIOD_US - 1);
  localparam us_t             MIN_W     = us_t'(MIN_US);
  localparam us_t             MAX_W     = us_t'(MAX_US);
  localparam us_t             DEFAULT_W = us_t'(DEFAULT_US);
  localparam logic [11:0]     TOP_ADDR  = BASE_ADDR + 12'd7;
  localparam logic [2:0]      BASE_LO   = BASE_ADDR[2:0];

  // Settings the timebase cannot honour; this branch elaborates to nothing.
  if (US_DIV < 2 || MAX_US >= PERIOD_US || SLEW_STEP_US < 1) begin : g_bad_config
  end

  us_t             target [NUM_SERVOS];
  logic [NUM_SERVOS-1:0] en_mask;
  logic [15:0]     frame_cnt;
  logic [PS_W-1:0] prescaler;
  us_t             us_cnt;
  logic [2:0]      off;
  logic            wr_en;
  logic            tick;
  logic            wrap;
  logic [31:0]     rd_next;

  // Full 32-bit compare so any upper-half bits saturate to the ceiling.
  function automatic us_t clamp_width(input logic [31:0] value);
    if (value < 32'(MIN_US)) begin
      return MIN_W;
    end else if (value > 32'(MAX_US)) begin
      return MAX_W;
    end else begin
      return value[15:0];
    end
  endfunction

  assign hit   = (addr >= BASE_ADDR) && (addr <= TOP_ADDR);
  assign off   = addr[2:0] - BASE_LO;
  assign wr_en = wren && hit;
  assign tick  = (prescaler == PS_LAST);
  assign wrap  = tick && (us_cnt == US_LAST);

  // Register-file writes; widths are clamped on the way in so readback shows the stored value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        target[i] <= DEFAULT_W;
      end
      en_mask <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        if (off == 3'(i)) begin
          target[i] <= clamp_width(wdata);
        end
      end
      if (off == OFF_EN) begin
        en_mask <= wdata[NUM_SERVOS-1:0];
      end
    end
  end

  // Timebase: prescaler makes a 1 us tick, us_cnt walks the frame, wrap bumps frame_cnt.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler   <= '0;
      us_cnt      <= '0;
      frame_cnt   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= wrap;
      if (tick) begin
        prescaler <= '0;
        us_cnt    <= wrap ? '0 : us_cnt + 16'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      if (wrap) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Readback mux; unimplemented offsets and out-of-window addresses read as zero.
  always_comb begin
    rd_next = '0;
    if (hit) begin
      for (int i = 0; i < NUM_SERVOS; i++) begin
        if (off == 3'(i)) begin
          rd_next = {16'b0, target[i]};
        end
      end
      if (off == OFF_EN) begin
        rd_next = 32'(en_mask);
      end
      if (off == OFF_STAT) begin
        rd_next = {16'b0, frame_cnt};
      end
    end
  end

  // Readback register gives the wrapper a fixed one-cycle load latency.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata <= '0;
    end else begin
      rdata <= rd_next;
    end
  end

  for (genvar i = 0; i < NUM_SERVOS; i++) begin : g_ch
    servo_pwm_channel #(
      .DEFAULT_US   (DEFAULT_US)
`ifdef SERVO_SLEW_EN
      , .SLEW_STEP_US (SLEW_STEP_US)
`endif
    ) u_ch (
      .clock  (clock),
      .reset  (reset),
      .us_cnt (us_cnt),
      .wrap   (wrap),
      .target (target[i]),
      .enable (en_mask[i]),
      .servo  (servo[i])
    );
  end

endmodule
